// File: rtl/text_lcd_monitor.sv
// Receive-side monitor of an HD44780-style 8-bit LCD write bus: mirrors a 2x16 buffer and checks busy timing.
// Optional transaction log outputs are enabled by defining TEXT_LCD_MONITOR_LOG_EN.
module text_lcd_monitor #(
  parameter int unsigned CMD_BUSY_US   = 37,
  parameter int unsigned CLEAR_BUSY_US = 1520,
  parameter int unsigned DATA_BUSY_US  = 37
) (
  input  logic        clk_1mhz,
  input  logic        rst,
  input  logic        lcd_rs,
  input  logic        lcd_rw,
  input  logic        lcd_en,
  input  logic [7:0]  lcd_data,
  input  logic [4:0]  rd_addr,
  output logic [7:0]  rd_char,
  output logic [6:0]  cursor_addr,
  output logic        display_on,
  output logic        two_line,
  output logic        busy,
  output logic        violation,
  output logic [15:0] txn_count
`ifdef TEXT_LCD_MONITOR_LOG_EN
  ,
  output logic        txn_valid,
  output logic        txn_rs,
  output logic [7:0]  txn_byte
`endif
);

  localparam int unsigned BUF_DEPTH = 32;
  localparam int unsigned IDX_W     = 5;
  localparam int unsigned AC_W      = 7;
  localparam int unsigned BUSY_MAX0 = (CMD_BUSY_US > DATA_BUSY_US) ? CMD_BUSY_US : DATA_BUSY_US;
  localparam int unsigned BUSY_MAX  = (CLEAR_BUSY_US > BUSY_MAX0) ? CLEAR_BUSY_US : BUSY_MAX0;
  localparam int unsigned CNT_W     = $clog2(BUSY_MAX + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  // DDRAM address counter step with the HD44780 two-line wrap points
  function automatic logic [AC_W-1:0] ac_step(input logic [AC_W-1:0] ac, input logic up);
    logic [AC_W-1:0] r;
    if (up) begin
      if (ac == 7'h27)      r = 7'h40;
      else if (ac == 7'h67) r = 7'h00;
      else                  r = ac + AC_W'(1);
    end else begin
      if (ac == 7'h40)      r = 7'h27;
      else if (ac == 7'h00) r = 7'h67;
      else                  r = ac - AC_W'(1);
    end
    return r;
  endfunction

  logic             rs_q, rw_q, en_q, en_prev_q;
  logic [7:0]       data_q;
  logic             rs_h, rw_h;
  logic [7:0]       data_h;
  logic             fall;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [AC_W-1:0]  ac_d;
  logic             inc_q, inc_d;
  logic             cgram_q, cgram_d;
  logic             disp_d, two_d, viol_d, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      txn_d;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [7:0]       wr_data;
  logic             log_valid_d;

  logic [7:0]       mem [BUF_DEPTH];

  assign fall = en_prev_q & ~en_q;

  // Bus capture; rs/rw/data are held from the last cycle the registered strobe was high
  always_ff @(posedge clk_1mhz) begin
    if (rst) begin
      rs_q      <= 1'b0;
      rw_q      <= 1'b0;
      en_q      <= 1'b0;
      en_prev_q <= 1'b0;
      data_q    <= 8'h00;
      rs_h      <= 1'b0;
      rw_h      <= 1'b0;
      data_h    <= 8'h00;
    end else begin
      rs_q      <= lcd_rs;
      rw_q      <= lcd_rw;
      en_q      <= lcd_en;
      en_prev_q <= en_q;
      data_q    <= lcd_data;
      if (en_q) begin
        rs_h   <= rs_q;
        rw_h   <= rw_q;
        data_h <= data_q;
      end
    end
  end

  // Next-state: sweep FSM, transaction decode, busy counter
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ac_d        = cursor_addr;
    inc_d       = inc_q;
    cgram_d     = cgram_q;
    disp_d      = display_on;
    two_d       = two_line;
    viol_d      = violation;
    cnt_d       = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    txn_d       = txn_count;
    wr_en       = 1'b0;
    wr_idx      = idx_q;
    wr_data     = 8'h20;
    log_valid_d = 1'b0;

    case (state_q)
      SWEEP: begin
        wr_en = 1'b1;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(BUF_DEPTH - 1)) state_d = IDLE;
      end
      default: ;
    endcase

    if (fall) begin
      if (busy) viol_d = 1'b1;
      if (state_q == SWEEP) begin
        // edge dropped while the buffer is being cleared
      end else if (rw_h) begin
        viol_d = 1'b1;
      end else begin
        txn_d       = txn_count + 16'd1;
        log_valid_d = 1'b1;
        if (rs_h) begin
          cnt_d = CNT_W'(DATA_BUSY_US);
          if (!cgram_q) begin
            if (cursor_addr[6:4] == 3'b000) begin
              wr_en   = 1'b1;
              wr_idx  = {1'b0, cursor_addr[3:0]};
              wr_data = data_h;
            end else if (cursor_addr[6:4] == 3'b100) begin
              wr_en   = 1'b1;
              wr_idx  = {1'b1, cursor_addr[3:0]};
              wr_data = data_h;
            end
            ac_d = ac_step(cursor_addr, inc_q);
          end
        end else begin
          cnt_d = CNT_W'(CMD_BUSY_US);
          casez (data_h)
            8'b1???????: begin
              ac_d    = data_h[6:0];
              cgram_d = 1'b0;
            end
            8'b01??????: cgram_d = 1'b1;
            8'b001?????: two_d = data_h[3];
            8'b0001????: if (!data_h[3]) ac_d = ac_step(cursor_addr, data_h[2]);
            8'b00001???: disp_d = data_h[2];
            8'b000001??: inc_d = data_h[1];
            8'b0000001?: begin
              ac_d  = '0;
              cnt_d = CNT_W'(CLEAR_BUSY_US);
            end
            8'b00000001: begin
              ac_d    = '0;
              inc_d   = 1'b1;
              cnt_d   = CNT_W'(CLEAR_BUSY_US);
              state_d = SWEEP;
              idx_d   = '0;
            end
            default: ;
          endcase
        end
      end
    end

    busy_d = (cnt_d != '0) || (state_d == SWEEP);
  end

  // State and output registers
  always_ff @(posedge clk_1mhz) begin
    if (rst) begin
      state_q     <= SWEEP;
      idx_q       <= '0;
      cursor_addr <= '0;
      inc_q       <= 1'b1;
      cgram_q     <= 1'b0;
      display_on  <= 1'b0;
      two_line    <= 1'b0;
      violation   <= 1'b0;
      cnt_q       <= '0;
      txn_count   <= '0;
      busy        <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cursor_addr <= ac_d;
      inc_q       <= inc_d;
      cgram_q     <= cgram_d;
      display_on  <= disp_d;
      two_line    <= two_d;
      violation   <= viol_d;
      cnt_q       <= cnt_d;
      txn_count   <= txn_d;
      busy        <= busy_d;
    end
  end

`ifdef TEXT_LCD_MONITOR_LOG_EN
  always_ff @(posedge clk_1mhz) begin
    if (rst) begin
      txn_valid <= 1'b0;
      txn_rs    <= 1'b0;
      txn_byte  <= 8'h00;
    end else begin
      txn_valid <= log_valid_d;
      if (log_valid_d) begin
        txn_rs   <= rs_h;
        txn_byte <= data_h;
      end
    end
  end
`else
  logic log_unused;
  assign log_unused = log_valid_d;
`endif

  // Character buffer; a read colliding with a write returns the old value
  always_ff @(posedge clk_1mhz) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    rd_char <= mem[rd_addr];
  end

endmodule
